aes_spi_ctrl: RTL

AES_SPI_CTRL -- requirements
Module: aes_spi_ctrl

---
 rtl/aes_spi_pkg.sv | 9 +
 rtl/sync_2ff.sv | 17 +
 rtl/aes_spi_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/aes_spi_pkg.sv
// aes_spi_pkg: shared FSM encoding and default sizes for the AES SPI controller.
package aes_spi_pkg;
  localparam int DATA_W_DEF = 128;
  localparam int TIMEOUT_DEF = 64;
  localparam logic [1:0] ST_KEY = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= 1'b0;
      q <= 1'b0;
    end else begin
      s1_q <= d;
      q <= s1_q;
    end
endmodule

// File: rtl/aes_spi_ctrl.sv
// aes_spi_ctrl: sequences SPI key/data frames into an AES core and returns ciphertext for shift-out.
module aes_spi_ctrl
  import aes_spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rx,
  input  logic              aes_done,
  input  logic [DATA_W-1:0] aes_out,
  output logic              aes_start,
  output logic [DATA_W-1:0] aes_key,
  output logic [DATA_W-1:0] aes_in,
  output logic [DATA_W-1:0] spi_tx,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic cs_s, done_s, cs_prev_q, frame_end, timeout;
  logic [1:0] fill_q, state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d, in_q, in_d, tx_q, tx_d;
  logic err_q, err_d, start_q, start_d, busy_q;
  logic [CW-1:0] cnt_q, cnt_d;
  sync_2ff u_sync_cs (.clk(clk), .rst_n(rst_n), .d(cs), .q(cs_s));
  sync_2ff u_sync_done (.clk(clk), .rst_n(rst_n), .d(spi_done), .q(done_s));
  // the zeroed synchronizer refill after reset must not look like a cs rising edge
  assign frame_end = cs_s & ~cs_prev_q;
  assign timeout = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    key_d = key_q;
    in_d = in_q;
    tx_d = tx_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (state_q == ST_RUN) begin
      cnt_d = cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
      if (aes_done) begin
        tx_d = aes_out;
        state_d = ST_READY;
      end else if (timeout) begin
        err_d = 1'b1;
        state_d = ST_DATA;
      end
      if (frame_end) err_d = 1'b1;
    end else if (frame_end) begin
      if (!done_s) err_d = 1'b1;
      else begin
        key_d = state_q == ST_KEY ? spi_rx : key_q;
        in_d = state_q == ST_KEY ? in_q : spi_rx;
        state_d = state_q == ST_KEY ? ST_DATA : ST_RUN;
      end
    end
    start_d = state_d == ST_RUN && state_q != ST_RUN;
    if (start_d) cnt_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fill_q <= 2'b00;
      cs_prev_q <= 1'b1;
      state_q <= ST_KEY;
      key_q <= '0;
      in_q <= '0;
      tx_q <= '0;
      err_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      fill_q <= {fill_q[0], 1'b1};
      cs_prev_q <= fill_q[1] ? cs_s : 1'b1;
      state_q <= state_d;
      key_q <= key_d;
      in_q <= in_d;
      tx_q <= tx_d;
      err_q <= err_d;
      start_q <= start_d;
      busy_q <= state_d == ST_RUN;
      cnt_q <= cnt_d;
    end
  assign aes_start = start_q;
  assign aes_key = key_q;
  assign aes_in = in_q;
  assign spi_tx = tx_q;
  assign busy = busy_q;
  assign err = err_q;
endmodule
